// File: rtl/elastic_pipe_reg.sv
// +--------------------------------------------------------------------------+
// | elastic_pipe_reg: inter-stage register with valid/ready, stall and flush |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module elastic_pipe_reg #(
  parameter int CTRL_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int SKID       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  generate
    if (SKID == 0) begin : g_single
      logic                  r_valid;
      logic [CTRL_WIDTH-1:0] r_ctrl;
      logic [DATA_WIDTH-1:0] r_data;
      logic                  w_xfer;

      assign in_ready = out_ready | ~r_valid;
      assign w_xfer   = in_valid & in_ready;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_valid <= 1'b0;
          r_ctrl  <= '0;
          r_data  <= '0;
        end else if (w_xfer) begin
          r_valid <= 1'b1;
          r_ctrl  <= in_ctrl;
          r_data  <= in_data;
        end else if (out_ready) begin
          // Consumed with no replacement: bubble keeps payload, kills control
          r_valid <= 1'b0;
          r_ctrl  <= '0;
        end
      end

      assign out_valid = r_valid;
      assign out_ctrl  = r_ctrl;
      assign out_data  = r_data;
      assign occupancy = {1'b0, r_valid};
    end else begin : g_skid
      localparam logic [1:0] ST_EMPTY = 2'd0;
      localparam logic [1:0] ST_ONE   = 2'd1;
      localparam logic [1:0] ST_TWO   = 2'd2;

      logic [1:0]            r_state;
      logic [CTRL_WIDTH-1:0] r_main_ctrl;
      logic [DATA_WIDTH-1:0] r_main_data;
      logic [CTRL_WIDTH-1:0] r_skid_ctrl;
      logic [DATA_WIDTH-1:0] r_skid_data;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_state     <= ST_EMPTY;
          r_main_ctrl <= '0;
          r_main_data <= '0;
          r_skid_ctrl <= '0;
          r_skid_data <= '0;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (in_valid) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
                r_state     <= ST_ONE;
              end
            end
            ST_ONE: begin
              if (out_ready && in_valid) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
              end else if (out_ready) begin
                r_main_ctrl <= '0;
                r_state     <= ST_EMPTY;
              end else if (in_valid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
                r_state     <= ST_TWO;
              end
            end
            ST_TWO: begin
              if (out_ready) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
                r_skid_ctrl <= '0;
                r_skid_data <= '0;
                r_state     <= ST_ONE;
              end
            end
            default: r_state <= ST_EMPTY;
          endcase
        end
      end

      // State encoding is the entry count, so ready decodes straight from a flop
      assign in_ready  = (r_state != ST_TWO);
      assign out_valid = (r_state != ST_EMPTY);
      assign out_ctrl  = r_main_ctrl;
      assign out_data  = r_main_data;
      assign occupancy = r_state;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_elastic_pipe_reg.sv
// Testbench for elastic_pipe_reg: both SKID variants share stimulus, each
// checked against its own FIFO reference model.
`default_nettype none

module tb_elastic_pipe_reg;

  localparam int CW = 16;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          w_in_ready [2];
  logic          w_out_valid[2];
  logic [CW-1:0] w_out_ctrl [2];
  logic [DW-1:0] w_out_data [2];
  logic [1:0]    w_occ      [2];

  always #5 clk = ~clk;

  elastic_pipe_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready[0]),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(w_out_valid[0]), .out_ready(out_ready),
    .out_ctrl(w_out_ctrl[0]), .out_data(w_out_data[0]),
    .occupancy(w_occ[0])
  );

  elastic_pipe_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready[1]),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(w_out_valid[1]), .out_ready(out_ready),
    .out_ctrl(w_out_ctrl[1]), .out_data(w_out_data[1]),
    .occupancy(w_occ[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: FIFO of capacity SKID+1 per variant, plus last shown payload
  logic [CW-1:0] m_ctrl[2][2];
  logic [DW-1:0] m_data[2][2];
  int            m_n[2];
  logic [DW-1:0] m_last[2];
  bit            started = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit fl, input bit iv, input bit ordy,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    bit exp_rdy, pop, push;
    @(negedge clk);
    rst = r; flush = fl; in_valid = iv; out_ready = ordy; in_ctrl = c; in_data = d;
    #1;
    for (int s = 0; s < 2; s++) begin
      exp_rdy = (s == 1) ? (m_n[s] < 2) : (ordy || m_n[s] == 0);
      if (started) begin
        check($sformatf("s%0d in_ready", s), DW'(w_in_ready[s]), DW'(exp_rdy));
        check($sformatf("s%0d out_valid", s), DW'(w_out_valid[s]), DW'(m_n[s] > 0));
        check($sformatf("s%0d out_ctrl", s), DW'(w_out_ctrl[s]),
              (m_n[s] > 0) ? DW'(m_ctrl[s][0]) : '0);
        check($sformatf("s%0d out_data", s), w_out_data[s],
              (m_n[s] > 0) ? m_data[s][0] : m_last[s]);
        check($sformatf("s%0d occupancy", s), DW'(w_occ[s]), DW'(m_n[s]));
      end
      if (r || fl) begin
        m_n[s]    = 0;
        m_last[s] = '0;
      end else begin
        pop  = (m_n[s] > 0) && ordy;
        push = iv && exp_rdy;
        if (pop) begin
          m_ctrl[s][0] = m_ctrl[s][1];
          m_data[s][0] = m_data[s][1];
          m_n[s]--;
        end
        if (push) begin
          m_ctrl[s][m_n[s]] = c;
          m_data[s][m_n[s]] = d;
          m_n[s]++;
        end
        if (m_n[s] > 0) m_last[s] = m_data[s][0];
      end
    end
    if (r) started = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    for (int s = 0; s < 2; s++) begin
      m_n[s] = 0;
      m_last[s] = '0;
    end

    cycle(1, 0, 0, 0, '0, '0);
    cycle(1, 0, 0, 0, '0, '0);
    cycle(0, 0, 0, 1, '0, '0);

    // Back-to-back stream with downstream always ready
    for (int i = 1; i <= 5; i++) cycle(0, 0, 1, 1, CW'(i), rnd_data());
    cycle(0, 0, 0, 1, '0, '0);
    cycle(0, 0, 0, 1, '0, '0);

    // Stall in the middle of an A0..A7 stream
    for (int t = 0; t < 12; t++)
      cycle(0, 0, (t < 8), !(t >= 3 && t <= 5), CW'(16'h00A0 + (t % 8)), rnd_data());

    // Fill, then flush with a coinciding offer
    cycle(0, 0, 1, 0, 16'h0011, rnd_data());
    cycle(0, 0, 1, 0, 16'h0022, rnd_data());
    cycle(0, 1, 1, 0, 16'h00FF, rnd_data());
    cycle(0, 0, 0, 1, '0, '0);
    cycle(0, 0, 0, 1, '0, '0);

    // Reset mid-stream under stall, then restart
    cycle(0, 0, 1, 0, 16'h0033, rnd_data());
    cycle(0, 0, 1, 0, 16'h0044, rnd_data());
    cycle(1, 0, 1, 0, 16'h0055, rnd_data());
    cycle(0, 0, 1, 1, 16'h0066, rnd_data());
    cycle(0, 0, 0, 1, '0, '0);

    // Alternating valid with ready held high
    for (int t = 0; t < 8; t++) cycle(0, 0, (t % 2 == 0), 1, CW'(16'h0100 + t), rnd_data());

    // Randomised traffic
    for (int t = 0; t < 10000; t++) begin
      cycle(($urandom_range(0, 511) == 0), ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
            CW'($urandom), rnd_data());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
